exec_issue_ctrl: RTL and testbench

EXEC_ISSUE_CTRL -- requirements
Module: exec_issue_ctrl

---
 rtl/exec_pkg.sv | 15 +
 rtl/exec_sel_decode.sv | 12 +
 rtl/exec_issue_ctrl.sv | 92 +++++++++
 tb/tb_exec_issue_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: select codes, FSM state type and defaults shared by the issue controller
package exec_pkg;
    localparam logic [4:0] SEL_PASS = 5'b00000;
    localparam logic [4:0] SEL_ADD  = 5'b00001;
    localparam logic [4:0] SEL_SUB  = 5'b00010;
    localparam logic [4:0] SEL_ADC  = 5'b00011;
    localparam logic [4:0] SEL_AND  = 5'b00110;
    localparam logic [4:0] SEL_OR   = 5'b00111;
    localparam logic [4:0] SEL_DIV  = 5'b01000;
    localparam logic [4:0] SEL_SHL  = 5'b10000;
    localparam logic [4:0] SEL_SHR  = 5'b10001;
    localparam int DIV_LAT_DEF = 4;
    localparam int DIV_CW      = 4;
    typedef enum logic {IDLE, DIV_BUSY} state_t;
endpackage

// File: rtl/exec_sel_decode.sv
// exec_sel_decode: classifies a select code as legal and/or multi-cycle
module exec_sel_decode
    import exec_pkg::*;
(
    input  logic [4:0] sel,
    output logic       legal,
    output logic       multicycle
);
    assign legal = sel inside {SEL_PASS, SEL_ADD, SEL_SUB, SEL_ADC, SEL_AND,
                               SEL_OR, SEL_DIV, SEL_SHL, SEL_SHR};
    assign multicycle = sel == SEL_DIV;
endmodule

// File: rtl/exec_issue_ctrl.sv
// exec_issue_ctrl: accepts decoded ops, stages them one edge, then strobes the executer.
// A flush during the staging cycle kills the strobe; a strobe already on the outputs stands.
module exec_issue_ctrl
    import exec_pkg::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [4:0]       op_sel,
    input  logic [4:0]       op_dst,
    input  logic [4:0]       op_reg3,
    input  logic             op_incr,
    input  logic             flush,
    output logic             ex_fire,
    output logic [4:0]       ex_sel,
    output logic [4:0]       ex_dst,
    output logic [4:0]       ex_reg3,
    output logic             ex_incr,
    output logic             busy,
    output logic             illegal_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] retired_cnt
);
    logic              legal, multi, take, s_valid, s_legal, s_incr, fire_next;
    logic [4:0]        s_sel, s_dst, s_reg3;
    logic [DIV_CW-1:0] div_cnt;
    state_t            state;

    exec_sel_decode u_dec (.sel(op_sel), .legal(legal), .multicycle(multi));

    assign op_ready  = rst_n && !flush && state == IDLE;
    assign take      = op_valid && op_ready;
    assign busy      = state == DIV_BUSY;
    assign fire_next = s_valid && s_legal && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            div_cnt       <= '0;
            s_valid       <= 1'b0;
            s_legal       <= 1'b0;
            s_sel         <= '0;
            s_dst         <= '0;
            s_reg3        <= '0;
            s_incr        <= 1'b0;
            ex_fire       <= 1'b0;
            ex_sel        <= '0;
            ex_dst        <= '0;
            ex_reg3       <= '0;
            ex_incr       <= 1'b0;
            illegal_pulse <= 1'b0;
            err_sticky    <= 1'b0;
            retired_cnt   <= '0;
        end else begin
            s_valid <= take;
            if (take) begin
                s_legal <= legal;
                s_sel   <= op_sel;
                s_dst   <= op_dst;
                s_reg3  <= op_reg3;
                s_incr  <= op_incr;
            end
            ex_fire       <= fire_next;
            illegal_pulse <= s_valid && !s_legal;
            if (s_valid && !s_legal)
                err_sticky <= 1'b1;
            if (fire_next) begin
                ex_sel      <= s_sel;
                ex_dst      <= s_dst;
                ex_reg3     <= s_reg3;
                ex_incr     <= s_incr;
                retired_cnt <= retired_cnt + 1'b1;
            end
            // the DIV's own strobe comes from the staging register, so busy only blocks intake
            if (flush) begin
                state   <= IDLE;
                div_cnt <= '0;
            end else if (take && multi && DIV_LAT > 1) begin
                state   <= DIV_BUSY;
                div_cnt <= DIV_CW'(DIV_LAT - 1);
            end else if (state == DIV_BUSY) begin
                div_cnt <= div_cnt - 1'b1;
                if (div_cnt == DIV_CW'(1))
                    state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_exec_issue_ctrl.sv
// tb_exec_issue_ctrl: directed scenarios plus random traffic against a cycle-indexed reference model
module tb_exec_issue_ctrl;
    localparam int DIV_LAT = 4;
    localparam int CNT_W   = 4;
    localparam logic [4:0] LEGAL [9] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h06, 5'h07, 5'h08, 5'h10, 5'h11};
    localparam logic [4:0] ADD = 5'h01, AND_ = 5'h06, OR_ = 5'h07, DIV = 5'h08, BAD = 5'h05;

    logic             clk = 1'b0, rst_n = 1'b0, op_valid = 1'b0, op_incr = 1'b0, flush = 1'b0;
    logic [4:0]       op_sel = '0, op_dst = '0, op_reg3 = '0;
    logic             op_ready, ex_fire, ex_incr, busy, illegal_pulse, err_sticky;
    logic [4:0]       ex_sel, ex_dst, ex_reg3;
    logic [CNT_W-1:0] retired_cnt;

    exec_issue_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op_sel(op_sel),
        .op_dst(op_dst), .op_reg3(op_reg3), .op_incr(op_incr), .flush(flush), .ex_fire(ex_fire),
        .ex_sel(ex_sel), .ex_dst(ex_dst), .ex_reg3(ex_reg3), .ex_incr(ex_incr), .busy(busy),
        .illegal_pulse(illegal_pulse), .err_sticky(err_sticky), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { bit v, legal, incr; logic [4:0] sel, dst, r3; } op_t;

    int n_vec = 0, n_err = 0, cyc = 0, busy_end = 0, busy_seen = 0, e_cnt = 0;
    int fires[$];
    op_t pend, e_ex;
    bit e_fire, e_ill, e_stk, stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_legal(input logic [4:0] s);
        for (int i = 0; i < 9; i++)
            if (s == LEGAL[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        pend = '{default: '0};
        e_ex = '{default: '0};
        e_fire = 0; e_ill = 0; e_stk = 0; e_cnt = 0; busy_end = 0; stall = 0;
    endfunction

    // one clock cycle: drive, check this cycle's outputs, then advance the model over the edge
    task automatic step(input bit rn, v, fl, input logic [4:0] sel, dst, r3, input bit inc);
        bit rdy, acc, fire;
        @(negedge clk);
        rst_n = rn; op_valid = v; flush = fl; op_sel = sel; op_dst = dst; op_reg3 = r3; op_incr = inc;
        #1;
        rdy = rn && !fl && !(cyc < busy_end);
        chk("ex_fire", ex_fire, e_fire);
        chk("ex_sel", ex_sel, e_ex.sel);
        chk("ex_dst", ex_dst, e_ex.dst);
        chk("ex_reg3", ex_reg3, e_ex.r3);
        chk("ex_incr", ex_incr, e_ex.incr);
        chk("busy", busy, cyc < busy_end);
        chk("illegal_pulse", illegal_pulse, e_ill);
        chk("err_sticky", err_sticky, e_stk);
        chk("retired_cnt", retired_cnt, e_cnt);
        chk("op_ready", op_ready, rdy);
        if (ex_fire === 1'b1) fires.push_back(cyc);
        if (busy === 1'b1) busy_seen++;
        if (!rn) model_reset();
        else begin
            acc  = v && rdy;
            fire = pend.v && pend.legal && !fl;
            e_fire = fire;
            if (fire) begin
                e_ex  = pend;
                e_cnt = (e_cnt + 1) % (1 << CNT_W);
            end
            e_ill = pend.v && !pend.legal;
            e_stk = e_stk || e_ill;
            if (fl) busy_end = 0;
            else if (acc && sel == DIV && DIV_LAT > 1) busy_end = cyc + DIV_LAT;
            pend  = '{v: acc, legal: is_legal(sel), incr: inc, sel: sel, dst: dst, r3: r3};
            stall = v && !acc;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 0, 0, '0, '0, '0, 0);
    endtask

    initial begin
        logic [CNT_W-1:0] saved;
        bit v, fl, rn, inc;
        logic [4:0] sel, dst, r3;
        model_reset();
        repeat (2) @(posedge clk);
        idle(1);
        // ADD dst=3
        step(1, 1, 0, ADD, 5'd3, 5'd0, 0);
        idle(2);
        chk("add_fire", ex_fire, 1);
        chk("add_dst", ex_dst, 3);
        chk("add_cnt", retired_cnt, 1);
        idle(1);
        // DIV followed immediately by AND
        fires.delete();
        busy_seen = 0;
        step(1, 1, 0, DIV, 5'd4, 5'd5, 0);
        repeat (5) step(1, 1, 0, AND_, 5'd6, 5'd7, 1);
        idle(3);
        chk("div_busy_cycles", busy_seen, DIV_LAT - 1);
        chk("div_fire_count", fires.size(), 3);
        if (fires.size() >= 2) chk("div_and_gap", fires[1] - fires[0], DIV_LAT);
        // illegal select
        step(1, 1, 0, BAD, 5'd9, 5'd9, 0);
        idle(2);
        chk("ill_pulse", illegal_pulse, 1);
        chk("ill_nofire", ex_fire, 0);
        idle(3);
        chk("ill_pulse_off", illegal_pulse, 0);
        chk("ill_sticky", err_sticky, 1);
        // flush kills a staged ADD
        saved = retired_cnt;
        step(1, 1, 0, ADD, 5'd11, 5'd0, 0);
        step(1, 0, 1, '0, '0, '0, 0);
        idle(1);
        chk("flush_nofire", ex_fire, 0);
        chk("flush_cnt", retired_cnt, saved);
        // 17 back-to-back ORs after reset wrap a 4-bit counter to 1
        step(0, 0, 0, '0, '0, '0, 0);
        chk("rst_sticky_pending", err_sticky, 1);
        idle(1);
        chk("rst_sticky_clear", err_sticky, 0);
        for (int i = 0; i < 17; i++) step(1, 1, 0, OR_, 5'(i), 5'(i + 1), i[0]);
        idle(2);
        chk("or_wrap_cnt", retired_cnt, 1);
        // reset during the second DIV_BUSY cycle
        step(1, 1, 0, DIV, 5'd2, 5'd3, 0);
        idle(1);
        step(0, 0, 0, '0, '0, '0, 0);
        idle(1);
        chk("rst_div_busy", busy, 0);
        chk("rst_div_ready", op_ready, 1);
        idle(1);
        // random traffic; stalled ops keep their fields
        v = 0; sel = '0; dst = '0; r3 = '0; inc = 0;
        for (int i = 0; i < 600; i++) begin
            rn = $urandom_range(0, 49) != 0;
            fl = $urandom_range(0, 9) == 0;
            if (!stall) begin
                v   = $urandom_range(0, 3) != 0;
                sel = $urandom_range(0, 3) == 0 ? 5'($urandom) :
                      $urandom_range(0, 3) == 0 ? DIV : LEGAL[$urandom_range(0, 8)];
                dst = 5'($urandom);
                r3  = 5'($urandom);
                inc = 1'($urandom);
            end
            step(rn, v, fl, sel, dst, r3, inc);
        end
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
